// File: rtl/lifo_drain_seq.sv
// Read-side sequencer for the calculator result LIFO: pops entries on dump/step requests and
// holds each popped result/opcode on the display outputs for a fixed dwell.
module lifo_drain_seq #(
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned OP_W       = 3,
  parameter int unsigned HOLD_TICKS = 600,
  parameter int unsigned CNT_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_dump,
  input  logic              i_step,
  input  logic              i_abort,
  input  logic              i_flag_clr,
  input  logic [DATA_W-1:0] i_tos_data,
  input  logic [OP_W-1:0]   i_tos_op,
  input  logic              i_lifo_empty,
  output logic              o_pop,
  output logic [DATA_W-1:0] o_result_out,
  output logic [OP_W-1:0]   o_opcode_out,
  output logic              o_valid,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_pop_count,
  output logic              o_underrun
);

  localparam int unsigned DwellW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StPop, StHold, StDone} state_e;
  typedef enum logic {ModeDrain, ModeStep} mode_e;

  state_e              r_state, w_state_nxt;
  mode_e               r_mode, w_mode_nxt;
  logic [DwellW-1:0]   r_dwell, w_dwell_nxt;
  logic [DATA_W-1:0]   r_result, w_result_nxt;
  logic [OP_W-1:0]     r_op, w_op_nxt;
  logic                r_valid, w_valid_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic                r_underrun, w_underrun_nxt;
  logic                r_pop;
  logic                w_pop;

  // Registered strobe, gated so the LIFO never sees a pop when empty or while aborting.
  assign w_pop = r_pop & ~i_lifo_empty & ~i_abort;

  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_dwell_nxt    = r_dwell;
    w_result_nxt   = r_result;
    w_op_nxt       = r_op;
    w_valid_nxt    = r_valid;
    w_count_nxt    = r_count;
    w_underrun_nxt = r_underrun;

    if (i_flag_clr) begin
      w_underrun_nxt = 1'b0;
    end

    if (i_abort) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_dump || i_step) begin
            if (i_lifo_empty) begin
              w_underrun_nxt = 1'b1;
            end else begin
              w_state_nxt = StPop;
              w_mode_nxt  = i_dump ? ModeDrain : ModeStep;
              w_count_nxt = '0;
            end
          end
        end
        StPop: begin
          if (w_pop) begin
            w_result_nxt = i_tos_data;
            w_op_nxt     = i_tos_op;
            w_valid_nxt  = 1'b1;
            w_dwell_nxt  = '0;
            w_state_nxt  = StHold;
            if (r_count != '1) begin
              w_count_nxt = r_count + CNT_W'(1);
            end
          end else begin
            w_state_nxt = StDone;
          end
        end
        StHold: begin
          if (r_dwell == DwellLast) begin
            if (r_mode == ModeDrain && !i_lifo_empty) begin
              w_state_nxt = StPop;
            end else begin
              w_state_nxt = StDone;
            end
          end else begin
            w_dwell_nxt = r_dwell + DwellW'(1);
          end
        end
        StDone: begin
          w_state_nxt = StIdle;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_mode     <= ModeDrain;
      r_dwell    <= '0;
      r_result   <= '0;
      r_op       <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_underrun <= 1'b0;
      r_pop      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_dwell    <= w_dwell_nxt;
      r_result   <= w_result_nxt;
      r_op       <= w_op_nxt;
      r_valid    <= w_valid_nxt;
      r_count    <= w_count_nxt;
      r_underrun <= w_underrun_nxt;
      r_pop      <= (w_state_nxt == StPop);
    end
  end

  assign o_pop        = w_pop;
  assign o_result_out = r_result;
  assign o_opcode_out = r_op;
  assign o_valid      = r_valid;
  assign o_busy       = (r_state != StIdle);
  assign o_pop_count  = r_count;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_lifo_drain_seq.sv
// Directed bench for lifo_drain_seq with a behavioural LIFO on the read side.
module tb_lifo_drain_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dump = 1'b0, step = 1'b0, abort = 1'b0, flag_clr = 1'b0;
  logic [5:0] tos_data;
  logic [2:0] tos_op;
  logic       lifo_empty;
  logic       pop;
  logic [5:0] result_out;
  logic [2:0] opcode_out;
  logic       valid, busy, underrun;
  logic [3:0] pop_count;

  int total = 0;
  int bad = 0;

  // LIFO model: entry sp-1 is top of stack
  logic [5:0] st_d [0:31];
  logic [2:0] st_o [0:31];
  int         sp = 0;
  int         ld_sp = 0;
  logic       ld = 1'b0;
  logic       prev_pop = 1'b0;
  logic       viol = 1'b0;

  assign lifo_empty = (sp == 0);
  assign tos_data   = (sp > 0) ? st_d[sp-1] : 6'd0;
  assign tos_op     = (sp > 0) ? st_o[sp-1] : 3'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) sp <= ld_sp;
    else if (pop && sp > 0) sp <= sp - 1;
    if (pop && (sp == 0 || prev_pop)) viol <= 1'b1;
    prev_pop <= pop;
  end

  lifo_drain_seq #(
    .DATA_W(6), .OP_W(3), .HOLD_TICKS(4), .CNT_W(4)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_dump(dump), .i_step(step), .i_abort(abort),
    .i_flag_clr(flag_clr), .i_tos_data(tos_data), .i_tos_op(tos_op),
    .i_lifo_empty(lifo_empty), .o_pop(pop), .o_result_out(result_out),
    .o_opcode_out(opcode_out), .o_valid(valid), .o_busy(busy), .o_pop_count(pop_count),
    .o_underrun(underrun)
  );

  task automatic load3;
    st_d[2] = 6'd12; st_o[2] = 3'd1;
    st_d[1] = 6'd5;  st_o[1] = 3'd2;
    st_d[0] = 6'd63; st_o[0] = 3'd0;
    @(negedge clk) ld = 1'b1; ld_sp = 3;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_timeout busy=%b required=0", name, busy);
    end
  endtask

  task automatic test_reset;
    #12;
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL rst_pop got=%b exp=0", pop); end
    total++; if (result_out !== 6'd0) begin bad++; $display("FAIL rst_result got=%0d exp=0", result_out); end
    total++; if (opcode_out !== 3'd0) begin bad++; $display("FAIL rst_opcode got=%0d exp=0", opcode_out); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (pop_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", pop_count); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_dump;
    logic [5:0] er;
    logic [2:0] eo;
    load3();
    @(negedge clk) dump = 1'b1;
    @(negedge clk) dump = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (pop !== 1'((i == 0) || (i == 5) || (i == 10))) begin
        bad++; $display("FAIL dump_pop[%0d] got=%b", i, pop);
      end
      if (i == 1 || i == 6 || i == 11) begin
        er = (i == 1) ? 6'd12 : (i == 6) ? 6'd5 : 6'd63;
        eo = (i == 1) ? 3'd1 : (i == 6) ? 3'd2 : 3'd0;
        total++;
        if (result_out !== er || opcode_out !== eo || valid !== 1'b1) begin
          bad++;
          $display("FAIL dump_entry[%0d] got=%0d/%0d v=%b exp=%0d/%0d v=1", i, result_out,
                   opcode_out, valid, er, eo);
        end
      end
      if (i <= 10) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dump_busy[%0d] got=%b exp=1", i, busy); end
      end
      @(negedge clk);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dump_idle got=%b exp=0", busy); end
    total++; if (pop_count !== 4'd3) begin bad++; $display("FAIL dump_count got=%0d exp=3", pop_count); end
    total++; if (result_out !== 6'd63) begin bad++; $display("FAIL dump_last got=%0d exp=63", result_out); end
  endtask

  task automatic test_step;
    logic [5:0] er;
    load3();
    for (int s = 0; s < 2; s++) begin
      er = (s == 0) ? 6'd12 : 6'd5;
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      for (int i = 0; i < 10; i++) begin
        total++;
        if (pop !== 1'(i == 0)) begin bad++; $display("FAIL step%0d_pop[%0d] got=%b", s, i, pop); end
        @(negedge clk);
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL step%0d_busy got=%b exp=0", s, busy); end
      total++; if (result_out !== er) begin bad++; $display("FAIL step%0d_result got=%0d exp=%0d", s, result_out, er); end
      total++; if (pop_count !== 4'd1) begin bad++; $display("FAIL step%0d_count got=%0d exp=1", s, pop_count); end
    end
  endtask

  task automatic test_underrun;
    @(negedge clk) ld = 1'b1; ld_sp = 0;
    @(negedge clk) ld = 1'b0; dump = 1'b1;
    @(negedge clk) dump = 1'b0;
    total++; if (pop !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL urun_nopop pop=%b busy=%b exp=0/0", pop, busy); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL urun_set got=%b exp=1", underrun); end
    flag_clr = 1'b1;
    @(negedge clk) flag_clr = 1'b0;
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL urun_clr got=%b exp=0", underrun); end
    step = 1'b1; flag_clr = 1'b1;
    @(negedge clk) step = 1'b0; flag_clr = 1'b0;
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL urun_prio got=%b exp=1", underrun); end
    flag_clr = 1'b1;
    @(negedge clk) flag_clr = 1'b0;
  endtask

  task automatic test_abort;
    load3();
    @(negedge clk) dump = 1'b1;
    @(negedge clk) dump = 1'b0;
    @(negedge clk);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    for (int i = 0; i < 12; i++) begin
      total++; if (pop !== 1'b0) begin bad++; $display("FAIL abort_pop[%0d] got=%b exp=0", i, pop); end
      @(negedge clk);
    end
    total++; if (result_out !== 6'd12 || valid !== 1'b1) begin
      bad++; $display("FAIL abort_hold got=%0d v=%b exp=12 v=1", result_out, valid);
    end
  endtask

  task automatic test_reset_mid;
    int npop = 0;
    load3();
    @(negedge clk) dump = 1'b1;
    @(negedge clk) dump = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (result_out !== 6'd0 || valid !== 1'b0 || busy !== 1'b0 || pop_count !== 4'd0 || pop !== 1'b0) begin
      bad++; $display("FAIL rstmid_outs got=%0d v=%b b=%b c=%0d p=%b exp=all0", result_out, valid,
                      busy, pop_count, pop);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++; if (pop !== 1'b0) begin bad++; $display("FAIL rstmid_pop[%0d] got=%b exp=0", i, pop); end
      @(negedge clk);
    end
    // second dump while busy must not add pops or restart the sequence
    load3();
    @(negedge clk) dump = 1'b1;
    @(negedge clk) dump = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) dump = 1'b1;
      if (i == 3) dump = 1'b0;
      if (pop) npop++;
      total++;
      if (pop !== 1'((i == 0) || (i == 5) || (i == 10))) begin
        bad++; $display("FAIL busydump_pop[%0d] got=%b", i, pop);
      end
      @(negedge clk);
    end
    wait_idle("busydump");
    total++; if (npop != 3 || pop_count !== 4'd3) begin
      bad++; $display("FAIL busydump_count got=%0d/%0d exp=3/3", npop, pop_count);
    end
  endtask

  task automatic test_saturate;
    int n = 0;
    for (int j = 0; j < 20; j++) begin
      st_d[j] = 6'(j * 3 + 1);
      st_o[j] = 3'(j);
    end
    @(negedge clk) ld = 1'b1; ld_sp = 20;
    @(negedge clk) ld = 1'b0; dump = 1'b1;
    @(negedge clk) dump = 1'b0;
    for (int c = 0; c < 130 && n < 20; c++) begin
      if (pop === 1'b1) begin
        @(negedge clk);
        total++;
        if (result_out !== 6'((19 - n) * 3 + 1) || opcode_out !== 3'(19 - n)) begin
          bad++; $display("FAIL sat_entry[%0d] got=%0d/%0d exp=%0d/%0d", n, result_out, opcode_out,
                          (19 - n) * 3 + 1, (19 - n) % 8);
        end
        n++;
      end else begin
        @(negedge clk);
      end
    end
    total++; if (n != 20) begin bad++; $display("FAIL sat_npop got=%0d exp=20", n); end
    wait_idle("sat");
    total++; if (pop_count !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", pop_count); end
  endtask

  task automatic test_protocol;
    total++; if (viol !== 1'b0) begin bad++; $display("FAIL pop_protocol got=%b exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_dump();
    test_step();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_saturate();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
